// File: rtl/divider.sv
// Sequential signed divider: restoring division on operand magnitudes, one quotient
// bit per clock, result packed as {remainder, quotient} with a start/busy/done handshake.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     Dvnd,
    input  logic [WIDTH-1:0]     Dvsr,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero,
    output logic [2*WIDTH-1:0]   Y
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        DIVIDE = 2'd2,
        FIXUP  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     dvnd_q, dvnd_d;
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;
    logic                 sign_quo_q, sign_quo_d;
    logic                 sign_rem_q, sign_rem_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;
    logic [2*WIDTH-1:0]   y_q, y_d;

    // The partial remainder always stays below M, so WIDTH bits hold it; the
    // trial subtraction needs one extra bit to expose the borrow.
    logic [WIDTH:0]       shift_a;
    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;

    assign shift_a   = {a_q, q_q[WIDTH-1]};
    assign diff      = shift_a - {1'b0, m_q};
    assign quotient  = sign_quo_q ? -q_q : q_q;
    assign remainder = sign_rem_q ? -a_q : a_q;

    // NOTE: every next-state signal gets a default first so no path leaves it
    // unassigned; that keeps this block purely combinational (no latches).
    always_comb begin
        state_d    = state_q;
        dvnd_d     = dvnd_q;
        dvsr_d     = dvsr_q;
        sign_quo_d = sign_quo_q;
        sign_rem_d = sign_rem_q;
        a_d        = a_q;
        q_d        = q_q;
        m_d        = m_q;
        count_d    = count_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dbz_d      = dbz_q;
        y_d        = y_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvnd_d     = Dvnd;
                    dvsr_d     = Dvsr;
                    sign_quo_d = Dvnd[WIDTH-1] ^ Dvsr[WIDTH-1];
                    sign_rem_d = Dvnd[WIDTH-1];
                    busy_d     = 1'b1;
                    dbz_d      = 1'b0;
                    state_d    = SETUP;
                end
            end

            SETUP: begin
                // Unsigned magnitudes: the most negative value maps onto itself.
                a_d     = '0;
                q_d     = dvnd_q[WIDTH-1] ? -dvnd_q : dvnd_q;
                m_d     = dvsr_q[WIDTH-1] ? -dvsr_q : dvsr_q;
                count_d = '0;
                state_d = DIVIDE;
            end

            DIVIDE: begin
                if (!diff[WIDTH]) begin
                    a_d = diff[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    a_d = shift_a[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q + 1'b1;
                if (count_q == LAST_COUNT) begin
                    state_d = FIXUP;
                end
            end

            FIXUP: begin
                if (dvsr_q == '0) begin
                    y_d   = {dvnd_q, {WIDTH{1'b1}}};
                    dbz_d = 1'b1;
                end else begin
                    y_d   = {remainder, quotient};
                    dbz_d = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            dvnd_q     <= '0;
            dvsr_q     <= '0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            a_q        <= '0;
            q_q        <= '0;
            m_q        <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            y_q        <= '0;
        end else begin
            state_q    <= state_d;
            dvnd_q     <= dvnd_d;
            dvsr_q     <= dvsr_d;
            sign_quo_q <= sign_quo_d;
            sign_rem_q <= sign_rem_d;
            a_q        <= a_d;
            q_q        <= q_d;
            m_q        <= m_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            y_q        <= y_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign Y           = y_q;

endmodule

// File: tb/tb_divider.sv
// Directed bench for the signed sequential divider: latency, busy width, signed
// results, edge operands, divide-by-zero, handshake corner cases and mid-op reset.
module tb_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dvnd;
    logic [31:0] dvsr;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [63:0] y;

    int checks   = 0;
    int failures = 0;

    divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .Dvnd        (dvnd),
        .Dvsr        (dvsr),
        .busy        (busy),
        .done        (done),
        .div_by_zero (dbz),
        .Y           (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge,
    // with start dropped and the operand inputs scrambled.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        dvnd  = a;
        dvsr  = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dvnd  = 32'hDEAD_BEEF;
        dvsr  = 32'h0;
    endtask

    // Counts edges after the accepting edge until done; optionally pokes a
    // 20/3 start request at edge count 'poke' while the operation is in flight.
    task automatic wait_done(input string tag, input int poke,
                             input logic [63:0] exp_y, input logic exp_dbz);
        int k;
        int bc;
        k  = 0;
        bc = 0;
        while (done !== 1'b1 && k < 60) begin
            if (busy === 1'b1) bc++;
            if (k == poke) begin
                start = 1'b1;
                dvnd  = 32'd20;
                dvsr  = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check($sformatf("%s.latency", tag), 64'(k), 64'd34);
        check($sformatf("%s.busy_cycles", tag), 64'(bc), 64'd34);
        check($sformatf("%s.busy_low", tag), 64'(busy), 64'd0);
        check($sformatf("%s.y", tag), y, exp_y);
        check($sformatf("%s.dbz", tag), 64'(dbz), 64'(exp_dbz));
    endtask

    initial begin
        bit saw;
        reset = 1'b0;
        start = 1'b0;
        dvnd  = '0;
        dvsr  = '0;
        #12;
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.dbz", 64'(dbz), 64'd0);
        check("rst.y", y, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Basic unsigned case plus done pulse width.
        issue(32'd100, 32'd7);
        wait_done("p100_p7", -1, {32'd2, 32'd14}, 1'b0);
        @(negedge clk);
        check("done_pulse_low", 64'(done), 64'd0);
        check("y_holds", y, {32'd2, 32'd14});

        // Signed combinations.
        issue(-32'sd100, 32'd7);
        wait_done("m100_p7", -1, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b0);
        @(negedge clk);
        issue(32'd100, -32'sd7);
        wait_done("p100_m7", -1, {32'd2, 32'hFFFF_FFF2}, 1'b0);
        @(negedge clk);
        issue(-32'sd100, -32'sd7);
        wait_done("m100_m7", -1, {32'hFFFF_FFFE, 32'd14}, 1'b0);
        @(negedge clk);

        // Edge operands.
        issue(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("min_div_m1", -1, {32'h0, 32'h8000_0000}, 1'b0);
        @(negedge clk);
        issue(32'h8000_0000, 32'd1);
        wait_done("min_div_1", -1, {32'h0, 32'h8000_0000}, 1'b0);
        @(negedge clk);
        issue(32'd0, 32'd5);
        wait_done("zero_div_5", -1, 64'h0, 1'b0);
        @(negedge clk);

        // Divide by zero, then a normal op clears the flag on acceptance.
        issue(32'd5, 32'd0);
        wait_done("div0", -1, {32'd5, 32'hFFFF_FFFF}, 1'b1);
        @(negedge clk);
        check("div0.flag_holds", 64'(dbz), 64'd1);
        issue(32'd9, 32'd3);
        check("dbz_clear_on_accept", 64'(dbz), 64'd0);
        wait_done("p9_p3", -1, {32'd0, 32'd3}, 1'b0);
        @(negedge clk);

        // Start during busy is ignored; start in the done cycle is accepted.
        issue(32'd100, 32'd7);
        wait_done("ignored_start", 5, {32'd2, 32'd14}, 1'b0);
        issue(32'd20, 32'd3);
        check("b2b.busy", 64'(busy), 64'd1);
        check("b2b.y_prev", y, {32'd2, 32'd14});
        wait_done("b2b_20_3", -1, {32'd2, 32'd6}, 1'b0);
        @(negedge clk);

        // Asynchronous reset mid-operation.
        issue(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst.busy", 64'(busy), 64'd0);
        check("midrst.done", 64'(done), 64'd0);
        check("midrst.y", y, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
        end
        check("midrst.no_done", 64'(saw), 64'd0);
        issue(-32'sd9, 32'd2);
        wait_done("m9_p2", -1, {32'hFFFF_FFFF, 32'hFFFF_FFFC}, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/divider.md
# divider

Sequential signed 32-bit divider for the datapath's DIV instruction, the inverse of the Booth multiplier. It takes a dividend and divisor and produces a quotient and remainder, one quotient bit per clock, using restoring division on magnitudes. The result is packed into a 64-bit `Y` with the same layout as the multiplier's product: `Y[63:32]` goes to HI and `Y[31:0]` goes to LO. A start/busy/done handshake lets the control unit stall until the result is ready.

## Interface
- `WIDTH`, default 32: operand width. The quotient and remainder are each `WIDTH` bits and `Y` is `2*WIDTH` bits. Only 32 is verified.
- `clk` input 1: clock. All state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset. `reset=0` clears the block immediately, independent of `clk`.
- `start` input 1: request a division. Sampled only in IDLE.
- `Dvnd` input 32: dividend, two's complement. Captured on the accepting edge.
- `Dvsr` input 32: divisor, two's complement. Captured on the accepting edge.
- `busy` output 1: high from the accepting edge until the result is written.
- `done` output 1: single-cycle pulse; `Y` is valid from this cycle onward.
- `div_by_zero` output 1: set with `done` when the captured divisor was 0. Holds until the next accepted start.
- `Y` output 64: `{remainder, quotient}`. Holds its value until the next result or reset.

## Operation
- States: IDLE, SETUP, DIVIDE, FIXUP.
- **IDLE**
  - On `start=1` at a rising edge: latch `Dvnd` and `Dvsr`, latch `sign_q = Dvnd[31]^Dvsr[31]` and `sign_r = Dvnd[31]`.
  - Set `busy=1`, clear `div_by_zero`, go to SETUP.
- **SETUP** (1 cycle)
  - `A = 33'b0`, `Q = |Dvnd|`, `M = |Dvsr|`, `count = 0`.
  - Magnitudes are unsigned 32-bit, so `|0x80000000| = 0x80000000`.
  - Go to DIVIDE.
- **DIVIDE** (exactly 32 cycles)
  - Each cycle, shift `{A,Q}` left by 1 and compute `A - M` as 33 bits.
  - If the result is non-negative: `A` takes it and `Q[0]=1`. Otherwise `A` is unchanged and `Q[0]=0`.
  - Increment `count`. After `count==31` is processed, go to FIXUP.
- **FIXUP** (1 cycle)
  - `quotient = sign_q ? -Q : Q` and `remainder = sign_r ? -A[31:0] : A[31:0]`.
  - The quotient truncates toward zero. The remainder takes the sign of the dividend.
  - Write `Y`, pulse `done`, drop `busy`, go to IDLE.
- **Divide by zero** (captured `Dvsr==0`)
  - The DIVIDE iterations still run, so latency is unchanged.
  - FIXUP overrides the result: `Y[31:0]=32'hFFFFFFFF`, `Y[63:32]=Dvnd` as captured, `div_by_zero=1`.
- **Overflow** (`0x80000000 / -1`): wraps. Quotient is `0x80000000`, remainder is 0. No flag is raised.
- `start` while `busy=1` is ignored. The in-flight operation and its captured operands are unaffected.
- Operand changes after the accepting edge have no effect.

## Timing
- Reset values: `busy=0`, `done=0`, `div_by_zero=0`, `Y=64'b0`, state IDLE, `count=0`.
- Latency:
  - Accepting edge E0.
  - SETUP is evaluated at E1.
  - DIVIDE iterations at E2 through E33.
  - FIXUP at E34: `Y` is updated, `done=1`, `busy=0`.
  - `done` is visible in the cycle after E34 and is low again after E35.
- `busy` is high for exactly 34 cycles per operation.
- Back-to-back operation: `start=1` in the cycle where `done=1` is accepted at E35, since the state is already IDLE.
  - `Y` holds the previous result until the new FIXUP.
  - `div_by_zero` clears at E35.
- Reset during an operation:
  - The operation is aborted and all outputs return to their reset values immediately.
  - No `done` is produced for the aborted operation.
  - The first rising edge after `reset` returns high may accept a new `start`.
- Throughput: one division per 35 cycles.

## Test plan
- `Dvnd=100`, `Dvsr=7`, one `start` pulse:
  - `done` 34 edges after the accepting edge.
  - `Y[31:0]=14`, `Y[63:32]=2`, `div_by_zero=0`.
  - `busy` high for exactly 34 cycles.
- Signed combinations, each with `Dvnd=±100` and `Dvsr=±7`:
  - `-100/7`: `Y[31:0]=0xFFFFFFF2`, `Y[63:32]=0xFFFFFFFE`.
  - `100/-7`: quotient `0xFFFFFFF2`, remainder `2`.
  - `-100/-7`: quotient `14`, remainder `0xFFFFFFFE`.
- Edge operands:
  - `0x80000000 / 0xFFFFFFFF`: `Y={32'h0, 32'h80000000}`.
  - `0x80000000 / 1`: quotient `0x80000000`, remainder 0.
  - `0 / 5`: `Y=0`.
- Divide by zero, `5 / 0`:
  - `Y[31:0]=0xFFFFFFFF`, `Y[63:32]=5`, `div_by_zero=1`, same 34-cycle latency.
  - A following `9/3` clears the flag and gives quotient 3, remainder 0.
- Handshake:
  - Pulse `start` with `20/3` at cycle 5 of `100/7`: it is ignored, and the result stays 14 rem 2.
  - Assert `start` with `20/3` in the `done` cycle: accepted, giving quotient 6, remainder 2 after 34 more edges.
- Reset mid-operation:
  - Drive `reset=0` at cycle 10 of `100/7`: `busy=0`, `Y=0`, and no `done` ever appears.
  - After release, `-9/2` gives quotient `0xFFFFFFFC`, remainder `0xFFFFFFFF`.
